pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
Parametrised control core for the pipelined successor of the single-cycle datapath. It owns per-stage valid bits, latch enables, stall/bubble/flush generation, load-use hazard detection, single-shot memory request gating and halt propagation. Stage latch payloads (instruction, operands, ALU result) stay in the datapath; this block only drives their enables and consumes a few decoded fields.

Parameters:
NSTAGES, 5, pipeline depth; stage 0 = IF, stage NSTAGES-1 = WB
ID_STAGE, 1, decode stage index
EX_STAGE, 2, stage that resolves branches and computes addresses
MEM_STAGE, 3, data-memory stage; legal only if ID_STAGE < EX_STAGE < MEM_STAGE < NSTAGES-1
RW, 5, register-select width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
id_rs, id_rt  in  RW each  source selects of the ID instruction
id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source
id_halt  in  1  ID instruction is a halt
ex_memread  in  1  EX instruction is a load
ex_wsel  in  RW  destination of the EX instruction
ex_branch_taken  in  1  EX instruction redirects the PC
mem_dREN, mem_dWEN  in  1 each  MEM instruction reads/writes memory
stage_en  out  NSTAGES  bit 0 = PC enable; bit i = enable of the latch feeding stage i
stage_valid  out  NSTAGES  stage i holds a real instruction (bit 0 is always 1 while fetching)
imemREN, dmemREN, dmemWEN  out  1 each  memory requests
halt  out  1  sticky processor halt

Behaviour:
- Clock CLK; reset nRST is asynchronous and active-low.
- Reset state: valid[NSTAGES-1:1]=0, halt_v=0, halt=0, halt_pending=0, ihit_seen=0, dhit_seen=0. After reset, imemREN=1 and the other outputs are 0.
- need_d = valid[MEM] & (mem_dREN | mem_dWEN).
- dmemREN = need_d & mem_dREN & ~dhit_seen; dmemWEN likewise with mem_dWEN. The block never issues the same access twice.
- imemREN = ~halt_pending & ~halt & ~ihit_seen.
- i_done = ihit | ihit_seen | halt_pending; d_done = ~need_d | dhit | dhit_seen; advance = i_done & d_done & ~halt.
- ihit_seen sets on ihit & ~advance and clears on advance. dhit_seen follows the same rule with dhit.
- hazard = valid[EX] & valid[ID] & ex_memread & (ex_wsel != 0) & ((id_uses_rs & id_rs == ex_wsel) | (id_uses_rt & id_rt == ex_wsel)).
- flush = valid[EX] & ex_branch_taken.
- If advance = 0: all stage_en are 0 and all state holds (full stall).
- If advance = 1 and flush = 1: all stage_en are 1; valid[ID] <= 0 and valid[EX] <= 0; later stages shift; hazard is ignored.
- If advance = 1, hazard = 1 and flush = 0: stage_en[EX:0] = 0 (PC and IF/ID hold); valid[EX] <= 0 (bubble); stages above EX shift.
- Otherwise, on advance: all stage_en are 1; valid[1] <= ~halt_pending; valid[i] <= valid[i-1] for i > 1.
- halt_v is a per-stage marker and shifts exactly like valid. It enters at EX from ID when valid[ID] & id_halt. It is cleared with valid on a flush.
- halt_pending sets when valid[ID] & id_halt & advance & ~flush. It clears only on reset. Once set, fetching stops, but older instructions drain.
- halt sets when valid[NSTAGES-1] & halt_v[NSTAGES-1], registered on the following edge. It is sticky until reset and freezes every stage.
- Reset asserted mid-stall or mid-access immediately clears all valid bits and seen flags.

Decomposition:
- cpu_types_pkg gains: regbits_t = logic [RW-1:0], a stage index typedef, and localparams IF_STAGE=0 and WB_STAGE=NSTAGES-1.
- Sub-module hazard_unit: purely combinational; computes hazard and flush from the ID/EX fields.
- The valid/halt shift register, the seen flags and the enable logic stay in pipeline_controller.

Test Plan:
- Reset, then ihit=1 every cycle with no memory ops -> stage_valid fills 00001, 00011 … 11111 over 4 cycles; stage_en=11111 each cycle.
- Load in EX with ex_wsel=5 and ID id_rs=5, id_uses_rs=1 -> one cycle with stage_en[2:0]=000 and valid[EX]=0 next; the ID instruction reaches EX one cycle later.
- Same case with ex_wsel=0 -> no stall.
- MEM load with dhit delayed 3 cycles and ihit arriving in cycle 1 -> dmemREN high for exactly 3 cycles; imemREN drops after cycle 1 (ihit_seen); stage_en=0 until dhit; single advance afterwards.
- ex_branch_taken with valid[EX]=1 while a load-use hazard is also present -> valid[ID] and valid[EX] are 0 next cycle; no hazard stall.
- halt in ID with 3 older instructions in flight -> imemREN=0 the next cycle; halt asserts once the marker reaches WB; halt stays 1 and stage_en=0 until nRST is pulsed low, which clears halt asynchronously.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared types and default geometry for the pipeline control core.
// Stage indices count from IF (0) up to WB (NSTAGES-1).
package pipeline_controller_pkg;

  localparam int NSTAGES_DEF   = 5;
  localparam int ID_STAGE_DEF  = 1;
  localparam int EX_STAGE_DEF  = 2;
  localparam int MEM_STAGE_DEF = 3;
  localparam int RW_DEF        = 5;

  localparam int IF_STAGE = 0;
  localparam int WB_STAGE = NSTAGES_DEF - 1;

  typedef logic [RW_DEF-1:0]               regbits_t;
  typedef logic [$clog2(NSTAGES_DEF)-1:0]  stage_idx_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the pipeline controller (master) and the datapath (slave).
// Decoded instruction fields and memory hits flow in; enables and memory requests flow out.
interface pipeline_controller_if
  import pipeline_controller_pkg::*;
#(
  parameter int NSTAGES = NSTAGES_DEF,
  parameter int RW      = RW_DEF
) ();

  logic               ihit;
  logic               dhit;
  logic [RW-1:0]      id_rs;
  logic [RW-1:0]      id_rt;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic               id_halt;
  logic               ex_memread;
  logic [RW-1:0]      ex_wsel;
  logic               ex_branch_taken;
  logic               mem_dREN;
  logic               mem_dWEN;
  logic [NSTAGES-1:0] stage_en;
  logic [NSTAGES-1:0] stage_valid;
  logic               imemREN;
  logic               dmemREN;
  logic               dmemWEN;
  logic               halt;

  modport master (
    input  ihit, dhit, id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
           ex_memread, ex_wsel, ex_branch_taken, mem_dREN, mem_dWEN,
    output stage_en, stage_valid, imemREN, dmemREN, dmemWEN, halt
  );

  modport slave (
    output ihit, dhit, id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
           ex_memread, ex_wsel, ex_branch_taken, mem_dREN, mem_dWEN,
    input  stage_en, stage_valid, imemREN, dmemREN, dmemWEN, halt
  );

endinterface

// File: rtl/pipeline_controller_hazard_unit.sv
// Combinational load-use hazard and branch flush detection from the ID/EX fields.
// Register 0 is hard-wired, so a load targeting it never creates a dependency.
module pipeline_controller_hazard_unit #(
  parameter int RW = 5
) (
  input  logic          valid_id_i,
  input  logic          valid_ex_i,
  input  logic          ex_memread_i,
  input  logic          ex_branch_taken_i,
  input  logic [RW-1:0] ex_wsel_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic          id_uses_rs_i,
  input  logic          id_uses_rt_i,
  output logic          hazard_o,
  output logic          flush_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs_i & (id_rs_i == ex_wsel_i);
  assign rt_match = id_uses_rt_i & (id_rt_i == ex_wsel_i);

  assign hazard_o = valid_ex_i & valid_id_i & ex_memread_i &
                    (ex_wsel_i != '0) & (rs_match | rt_match);

  assign flush_o  = valid_ex_i & ex_branch_taken_i;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline control core: per-stage valid/halt markers, latch enables, stalls, bubbles,
// flushes, single-shot memory request gating and sticky halt.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int NSTAGES   = NSTAGES_DEF,
  parameter int ID_STAGE  = ID_STAGE_DEF,
  parameter int EX_STAGE  = EX_STAGE_DEF,
  parameter int MEM_STAGE = MEM_STAGE_DEF,
  parameter int RW        = RW_DEF
) (
  input  logic                  CLK,
  input  logic                  nRST,
  pipeline_controller_if.master bus
);

  localparam int WB = NSTAGES - 1;

  logic [NSTAGES-1:1]          valid_q, valid_d;
  logic [NSTAGES-1:ID_STAGE+1] halt_v_q, halt_v_d;
  logic                        halt_pending_q, halt_pending_d;
  logic                        halt_q, halt_d;
  logic                        ihit_seen_q, ihit_seen_d;
  logic                        dhit_seen_q, dhit_seen_d;

  logic hazard;
  logic flush;
  logic front_stall;
  logic need_d;
  logic i_done;
  logic d_done;
  logic advance;
  logic fetching;

  pipeline_controller_hazard_unit #(.RW(RW)) u_hazard (
    .valid_id_i        (valid_q[ID_STAGE]),
    .valid_ex_i        (valid_q[EX_STAGE]),
    .ex_memread_i      (bus.ex_memread),
    .ex_branch_taken_i (bus.ex_branch_taken),
    .ex_wsel_i         (bus.ex_wsel),
    .id_rs_i           (bus.id_rs),
    .id_rt_i           (bus.id_rt),
    .id_uses_rs_i      (bus.id_uses_rs),
    .id_uses_rt_i      (bus.id_uses_rt),
    .hazard_o          (hazard),
    .flush_o           (flush)
  );

  // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
  assign front_stall = hazard & ~flush;

  assign need_d   = valid_q[MEM_STAGE] & (bus.mem_dREN | bus.mem_dWEN);
  assign fetching = ~halt_pending_q & ~halt_q;
  assign i_done   = bus.ihit | ihit_seen_q | halt_pending_q;
  assign d_done   = ~need_d | bus.dhit | dhit_seen_q;
  assign advance  = i_done & d_done & ~halt_q;

  assign bus.imemREN     = fetching & ~ihit_seen_q;
  assign bus.dmemREN     = need_d & bus.mem_dREN & ~dhit_seen_q;
  assign bus.dmemWEN     = need_d & bus.mem_dWEN & ~dhit_seen_q;
  assign bus.halt        = halt_q;
  assign bus.stage_valid = {valid_q, fetching};

  genvar gi;

  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage_en
      localparam bit FRONT = (gi <= EX_STAGE);
      assign bus.stage_en[gi] = advance & ~(front_stall & FRONT);
    end

    for (gi = 1; gi < NSTAGES; gi++) begin : g_valid
      localparam bit KILL   = (gi <= EX_STAGE);
      localparam bit HOLD   = (gi <  EX_STAGE);
      localparam bit BUBBLE = (gi == EX_STAGE);
      logic shift_v;

      if (gi == 1) begin : g_head
        assign shift_v = ~halt_pending_q;
      end else begin : g_body
        assign shift_v = valid_q[gi-1];
      end

      assign valid_d[gi] = ~advance                                 ? valid_q[gi] :
                           ((flush & KILL) | (front_stall & BUBBLE)) ? 1'b0        :
                           (front_stall & HOLD)                      ? valid_q[gi] :
                                                                       shift_v;
    end

    // Halt markers only exist downstream of decode, where the halt is first recognised.
    for (gi = ID_STAGE + 1; gi < NSTAGES; gi++) begin : g_halt_v
      localparam bit KILL   = (gi <= EX_STAGE);
      localparam bit HOLD   = (gi <  EX_STAGE);
      localparam bit BUBBLE = (gi == EX_STAGE);
      logic shift_h;

      if (gi == ID_STAGE + 1) begin : g_entry
        assign shift_h = valid_q[ID_STAGE] & bus.id_halt;
      end else begin : g_body
        assign shift_h = halt_v_q[gi-1];
      end

      assign halt_v_d[gi] = ~advance                                 ? halt_v_q[gi] :
                            ((flush & KILL) | (front_stall & BUBBLE)) ? 1'b0         :
                            (front_stall & HOLD)                      ? halt_v_q[gi] :
                                                                        shift_h;
    end
  endgenerate

  assign halt_pending_d = halt_pending_q |
                          (valid_q[ID_STAGE] & bus.id_halt & advance & ~flush);
  assign halt_d         = halt_q | (valid_q[WB] & halt_v_q[WB]);
  assign ihit_seen_d    = advance ? 1'b0 : (ihit_seen_q | bus.ihit);
  assign dhit_seen_d    = advance ? 1'b0 : (dhit_seen_q | bus.dhit);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q        <= '0;
      halt_v_q       <= '0;
      halt_pending_q <= 1'b0;
      halt_q         <= 1'b0;
      ihit_seen_q    <= 1'b0;
      dhit_seen_q    <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      halt_v_q       <= halt_v_d;
      halt_pending_q <= halt_pending_d;
      halt_q         <= halt_d;
      ihit_seen_q    <= ihit_seen_d;
      dhit_seen_q    <= dhit_seen_d;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus a randomized run,
// all checked against an instruction-occupancy model of the pipeline.
module tb_pipeline_controller;

  localparam int NSTG = 5;
  localparam int ID   = 1;
  localparam int EX   = 2;
  localparam int MEM  = 3;
  localparam int WB   = 4;

  logic CLK;
  logic nRST;

  pipeline_controller_if #(.NSTAGES(NSTG), .RW(5)) bus ();

  pipeline_controller #(
    .NSTAGES(NSTG), .ID_STAGE(ID), .EX_STAGE(EX), .MEM_STAGE(MEM), .RW(5)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total;
  int bad;

  // Model: occ[s] is the tag of the instruction in stage s (0 = empty), hmark flags halts.
  int         occ   [NSTG];
  bit         hmark [NSTG];
  bit         m_hp, m_halt, m_iseen, m_dseen;
  int         next_tag;
  bit         m_need, m_fl, m_hz, m_adv;
  logic [4:0] e_en, e_valid;
  logic       e_imem, e_dren, e_dwen, e_halt;

  task automatic model_reset();
    for (int s = 0; s < NSTG; s++) begin
      occ[s]   = 0;
      hmark[s] = 1'b0;
    end
    m_hp = 1'b0; m_halt = 1'b0; m_iseen = 1'b0; m_dseen = 1'b0;
  endtask

  task automatic model_comb();
    m_need = (occ[MEM] != 0) && (bus.mem_dREN || bus.mem_dWEN);
    m_fl   = (occ[EX] != 0) && bus.ex_branch_taken;
    m_hz   = (occ[EX] != 0) && (occ[ID] != 0) && bus.ex_memread && (bus.ex_wsel != 0) &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_wsel) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_wsel));
    m_adv  = (bus.ihit || m_iseen || m_hp) && (!m_need || bus.dhit || m_dseen) && !m_halt;
    for (int s = 0; s < NSTG; s++)
      e_en[s] = m_adv && !(m_hz && !m_fl && s <= EX);
    e_valid[0] = !m_hp && !m_halt;
    for (int s = 1; s < NSTG; s++)
      e_valid[s] = (occ[s] != 0);
    e_imem = !m_hp && !m_halt && !m_iseen;
    e_dren = m_need && bus.mem_dREN && !m_dseen;
    e_dwen = m_need && bus.mem_dWEN && !m_dseen;
    e_halt = m_halt;
  endtask

  task automatic model_edge();
    int nocc [NSTG];
    bit nh   [NSTG];
    bit retire_halt;
    model_comb();
    nocc = occ;
    nh   = hmark;
    retire_halt = (occ[WB] != 0) && hmark[WB];
    if (m_adv) begin
      for (int s = WB; s > EX; s--) begin
        nocc[s] = occ[s-1];
        nh[s]   = hmark[s-1];
      end
      if (m_fl) begin
        for (int s = 1; s <= EX; s++) begin
          nocc[s] = 0;
          nh[s]   = 1'b0;
        end
      end else if (m_hz) begin
        nocc[EX] = 0;
        nh[EX]   = 1'b0;
      end else begin
        for (int s = EX; s > 1; s--) begin
          nocc[s] = occ[s-1];
          nh[s]   = 1'b0;
        end
        nh[EX] = (occ[ID] != 0) && bus.id_halt;
        nh[1]  = 1'b0;
        if (m_hp) nocc[1] = 0;
        else begin
          nocc[1]  = next_tag;
          next_tag = next_tag + 1;
        end
      end
      if ((occ[ID] != 0) && bus.id_halt && !m_fl) m_hp = 1'b1;
      m_iseen = 1'b0;
      m_dseen = 1'b0;
    end else begin
      m_iseen = m_iseen | bus.ihit;
      m_dseen = m_dseen | bus.dhit;
    end
    if (retire_halt) m_halt = 1'b1;
    occ   = nocc;
    hmark = nh;
  endtask

  task automatic set_idle();
    bus.ihit = 1'b0; bus.dhit = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_halt = 1'b0; bus.ex_memread = 1'b0; bus.ex_wsel = '0;
    bus.ex_branch_taken = 1'b0; bus.mem_dREN = 1'b0; bus.mem_dWEN = 1'b0;
  endtask

  // Advance one clock: model follows the DUT edge, then return to the falling edge.
  task automatic clk_step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic refill(input int n);
    for (int k = 0; k < n; k++) begin
      set_idle();
      bus.ihit = 1'b1;
      clk_step();
    end
  endtask

  task automatic test_reset();
    set_idle();
    #1;
    model_comb();
    total++;
    if (bus.stage_valid !== 5'b00001) begin
      bad++; $display("FAIL reset_valid got=%b want=%b", bus.stage_valid, 5'b00001);
    end
    total++;
    if ({bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.halt} !== 4'b1000) begin
      bad++; $display("FAIL reset_req got=%b want=%b",
                      {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.halt}, 4'b1000);
    end
    total++;
    if (bus.stage_en !== 5'b00000) begin
      bad++; $display("FAIL reset_en got=%b want=%b", bus.stage_en, 5'b00000);
    end
    nRST = 1'b1;
  endtask

  task automatic test_fill();
    logic [4:0] want;
    for (int c = 0; c < 4; c++) begin
      set_idle();
      bus.ihit = 1'b1;
      #1;
      model_comb();
      total++;
      if (bus.stage_en !== 5'b11111) begin
        bad++; $display("FAIL fill_en c=%0d got=%b want=%b", c, bus.stage_en, 5'b11111);
      end
      clk_step();
      #1;
      want = 5'((1 << (c + 2)) - 1);
      total++;
      if (bus.stage_valid !== want) begin
        bad++; $display("FAIL fill_valid c=%0d got=%b want=%b", c, bus.stage_valid, want);
      end
    end
  endtask

  task automatic test_load_use();
    set_idle();
    bus.ihit = 1'b1; bus.ex_memread = 1'b1; bus.ex_wsel = 5'd5;
    bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
    #1;
    model_comb();
    total++;
    if (bus.stage_en !== 5'b11000 || bus.stage_en !== e_en) begin
      bad++; $display("FAIL loaduse_en got=%b want=%b", bus.stage_en, 5'b11000);
    end
    clk_step();
    set_idle();
    bus.ihit = 1'b1;
    #1;
    model_comb();
    total++;
    if (bus.stage_valid[EX] !== 1'b0 || bus.stage_valid[ID] !== 1'b1) begin
      bad++; $display("FAIL loaduse_bubble got=%b want=%b", bus.stage_valid[EX:ID], 2'b01);
    end
    clk_step();
    #1;
    total++;
    if (bus.stage_valid[EX] !== 1'b1) begin
      bad++; $display("FAIL loaduse_release got=%b want=%b", bus.stage_valid[EX], 1'b1);
    end
  endtask

  task automatic test_wsel_zero();
    refill(2);
    set_idle();
    bus.ihit = 1'b1; bus.ex_memread = 1'b1; bus.ex_wsel = 5'd0;
    bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
    #1;
    model_comb();
    total++;
    if (bus.stage_en !== 5'b11111 || bus.stage_en !== e_en) begin
      bad++; $display("FAIL wsel0_en got=%b want=%b", bus.stage_en, 5'b11111);
    end
    clk_step();
  endtask

  task automatic test_mem_wait();
    int dren_cycles;
    refill(3);
    dren_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      set_idle();
      bus.mem_dREN = 1'b1;
      bus.ihit     = (c == 0);
      bus.dhit     = (c == 2);
      #1;
      model_comb();
      if (bus.dmemREN === 1'b1) dren_cycles++;
      total++;
      if ({bus.stage_en, bus.imemREN, bus.dmemREN} !== {e_en, e_imem, e_dren}) begin
        bad++; $display("FAIL memwait c=%0d got=%b want=%b", c,
                        {bus.stage_en, bus.imemREN, bus.dmemREN}, {e_en, e_imem, e_dren});
      end
      total++;
      if (bus.stage_en !== ((c == 2) ? 5'b11111 : 5'b00000)) begin
        bad++; $display("FAIL memwait_en c=%0d got=%b want=%b", c, bus.stage_en,
                        (c == 2) ? 5'b11111 : 5'b00000);
      end
      if (c == 1) begin
        total++;
        if (bus.imemREN !== 1'b0) begin
          bad++; $display("FAIL memwait_imem got=%b want=%b", bus.imemREN, 1'b0);
        end
      end
      clk_step();
    end
    total++;
    if (dren_cycles != 3) begin
      bad++; $display("FAIL memwait_count got=%0d want=%0d", dren_cycles, 3);
    end
  endtask

  task automatic test_flush_hazard();
    refill(3);
    set_idle();
    bus.ihit = 1'b1; bus.ex_memread = 1'b1; bus.ex_wsel = 5'd7;
    bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1; bus.ex_branch_taken = 1'b1;
    #1;
    model_comb();
    total++;
    if (bus.stage_en !== 5'b11111) begin
      bad++; $display("FAIL flush_en got=%b want=%b", bus.stage_en, 5'b11111);
    end
    clk_step();
    set_idle();
    #1;
    total++;
    if (bus.stage_valid[EX:ID] !== 2'b00) begin
      bad++; $display("FAIL flush_valid got=%b want=%b", bus.stage_valid[EX:ID], 2'b00);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_idle();
      bus.ihit            = ($urandom_range(0, 99) < 70);
      bus.dhit            = ($urandom_range(0, 99) < 50);
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.id_uses_rs      = ($urandom_range(0, 1) == 1);
      bus.id_uses_rt      = ($urandom_range(0, 1) == 1);
      bus.ex_memread      = ($urandom_range(0, 99) < 40);
      bus.ex_wsel         = 5'($urandom_range(0, 3));
      bus.ex_branch_taken = ($urandom_range(0, 99) < 10);
      bus.mem_dREN        = ($urandom_range(0, 99) < 30);
      bus.mem_dWEN        = ($urandom_range(0, 99) < 20);
      #1;
      model_comb();
      total++;
      if ({bus.stage_en, bus.stage_valid, bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.halt} !==
          {e_en, e_valid, e_imem, e_dren, e_dwen, e_halt}) begin
        bad++; $display("FAIL random n=%0d got=%b want=%b", n,
          {bus.stage_en, bus.stage_valid, bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.halt},
          {e_en, e_valid, e_imem, e_dren, e_dwen, e_halt});
      end
      clk_step();
    end
  endtask

  task automatic test_halt();
    int  cycles;
    bit  seen;
    refill(4);
    set_idle();
    bus.ihit = 1'b1; bus.id_halt = 1'b1;
    #1;
    model_comb();
    total++;
    if (bus.stage_en !== 5'b11111 || bus.stage_valid !== 5'b11111) begin
      bad++; $display("FAIL halt_issue got=%b want=%b", {bus.stage_en, bus.stage_valid},
                      {5'b11111, 5'b11111});
    end
    clk_step();
    set_idle();
    #1;
    total++;
    if (bus.imemREN !== 1'b0) begin
      bad++; $display("FAIL halt_imem got=%b want=%b", bus.imemREN, 1'b0);
    end
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 10) begin
      set_idle();
      #1;
      model_comb();
      total++;
      if ({bus.stage_en, bus.stage_valid, bus.imemREN, bus.halt} !==
          {e_en, e_valid, e_imem, e_halt}) begin
        bad++; $display("FAIL halt_drain k=%0d got=%b want=%b", cycles,
          {bus.stage_en, bus.stage_valid, bus.imemREN, bus.halt},
          {e_en, e_valid, e_imem, e_halt});
      end
      if (bus.halt === 1'b1) seen = 1'b1;
      else begin
        clk_step();
        cycles++;
      end
    end
    total++;
    if (!seen || cycles != WB - EX + 1) begin
      bad++; $display("FAIL halt_latency got=%0d want=%0d (seen=%0d)", cycles, WB - EX + 1, seen);
    end
    for (int k = 0; k < 4; k++) begin
      set_idle();
      bus.ihit = ($urandom_range(0, 1) == 1);
      bus.dhit = ($urandom_range(0, 1) == 1);
      #1;
      total++;
      if (bus.halt !== 1'b1 || bus.stage_en !== 5'b00000) begin
        bad++; $display("FAIL halt_sticky k=%0d got=%b want=%b", k,
                        {bus.halt, bus.stage_en}, {1'b1, 5'b00000});
      end
      clk_step();
    end
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    total++;
    if (bus.halt !== 1'b0 || bus.stage_valid !== 5'b00001 || bus.imemREN !== 1'b1) begin
      bad++; $display("FAIL halt_async_reset got=%b want=%b",
                      {bus.halt, bus.stage_valid, bus.imemREN}, {1'b0, 5'b00001, 1'b1});
    end
    @(negedge CLK);
    nRST = 1'b1;
    set_idle();
    bus.ihit = 1'b1;
    #1;
    model_comb();
    total++;
    if (bus.stage_en !== 5'b11111 || bus.stage_en !== e_en) begin
      bad++; $display("FAIL halt_restart got=%b want=%b", bus.stage_en, 5'b11111);
    end
    clk_step();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    next_tag = 1;
    nRST     = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge CLK);
    test_reset();
    test_fill();
    test_load_use();
    test_wsel_zero();
    test_mem_wait();
    test_flush_hazard();
    test_random();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
